ins_mem_loader: RTL and testbench

- Writer side of the instruction BRAM: drives port A (clka/ena/wea/addra/dina) of the dual-port instruction memory, whose port B is read by the PC-driven decoder.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 64-bit instruction words.
- Writes the words to consecutive addresses from 0, then flags completion so the processor can be released from hold.

---
 rtl/ins_mem_loader_pkg.sv | 22 ++
 rtl/ins_mem_loader_if.sv | 34 +++
 rtl/ins_mem_loader_assembler.sv | 55 +++++
 rtl/ins_mem_loader.sv | 155 +++++++++++++++
 tb/tb_ins_mem_loader.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ins_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// simd_pkg
// Shared types and default widths for the instruction memory loader.
//   loader_state_e      : loader FSM states
//   INS_WIDTH_DEF       : default instruction word width (bits)
//   INS_ADDR_WIDTH_DEF  : default instruction memory address width (bits)
// -----------------------------------------------------------------------------
package simd_pkg;

   localparam int INS_WIDTH_DEF      = 64;
   localparam int INS_ADDR_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      WRITE,
      CHK,
      DONE
   } loader_state_e;

endpackage : simd_pkg

// File: rtl/ins_mem_loader_if.sv
// -----------------------------------------------------------------------------
// ins_mem_loader_if
// Byte stream input plus BRAM port-A write side of the instruction loader.
//   s_data/s_valid/s_ready : byte stream, transfer when s_valid & s_ready
//   ins_wea/ins_addra/ins_dina : instruction BRAM port-A write
// Modports:
//   master : the loader (consumes the stream, drives the BRAM port)
//   slave  : the environment (stream source, BRAM)
// -----------------------------------------------------------------------------
interface ins_mem_loader_if
   import simd_pkg::*;
#(
   parameter int INS_ADDR_WIDTH = INS_ADDR_WIDTH_DEF,
   parameter int INS_WIDTH      = INS_WIDTH_DEF
);

   logic [7:0]                s_data;
   logic                      s_valid;
   logic                      s_ready;
   logic                      ins_wea;
   logic [INS_ADDR_WIDTH-1:0] ins_addra;
   logic [INS_WIDTH-1:0]      ins_dina;

   modport master (
      input  s_data, s_valid,
      output s_ready, ins_wea, ins_addra, ins_dina
   );

   modport slave (
      output s_data, s_valid,
      input  s_ready, ins_wea, ins_addra, ins_dina
   );

endinterface : ins_mem_loader_if

// File: rtl/ins_mem_loader_assembler.sv
// -----------------------------------------------------------------------------
// ins_word_assembler
// Places stream bytes little-endian into an instruction word.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : restart assembly at byte 0 with an all-zero word
//   byte_en    : byte_in is accepted this cycle
//   byte_in    : stream byte
//   word       : word including the byte accepted this cycle
//   word_full  : the byte accepted this cycle completes the word
// -----------------------------------------------------------------------------
module ins_word_assembler #(
   parameter int INS_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 byte_en,
   input  logic [7:0]           byte_in,
   output logic [INS_WIDTH-1:0] word,
   output logic                 word_full
);

   localparam int BYTES_PER_INS = INS_WIDTH / 8;
   localparam int CNT_W         = (BYTES_PER_INS > 1) ? $clog2(BYTES_PER_INS) : 1;

   logic [CNT_W-1:0]     cnt;
   logic [INS_WIDTH-1:0] word_q;

   // The merged word is visible in the accepting cycle so the top can capture
   // it on the same edge that moves the FSM into WRITE.
   // NOTE: combinational blocks assign every output first; this avoids latches.
   always_comb begin
      word = word_q;
      if (byte_en) begin
         word[8*cnt +: 8] = byte_in;
      end
   end

   assign word_full = byte_en && (cnt == CNT_W'(BYTES_PER_INS - 1));

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         word_q <= '0;
      end else if (clear) begin
         cnt    <= '0;
         word_q <= '0;
      end else if (byte_en) begin
         word_q <= word;
         cnt    <= word_full ? '0 : cnt + 1'b1;
      end
   end

endmodule : ins_word_assembler

// File: rtl/ins_mem_loader.sv
// -----------------------------------------------------------------------------
// ins_mem_loader
// Loads a program into the instruction BRAM from a byte stream. The stream is
// a little-endian header holding (number of instructions - 1), followed by the
// instruction words, each little-endian.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a load (honoured in IDLE or DONE only)
//   bus      : stream input and BRAM port-A write (ins_mem_loader_if.master)
//   busy     : load in progress, processor held
//   done     : load complete, sticky until the next start
//   err      : checksum mismatch
// Build option: INS_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that
// is compared against all header and data bytes; without it err is tied 0.
// -----------------------------------------------------------------------------
module ins_mem_loader
   import simd_pkg::*;
#(
   parameter int INS_ADDR_WIDTH = INS_ADDR_WIDTH_DEF,
   parameter int INS_WIDTH      = INS_WIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   ins_mem_loader_if.master  bus,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_BYTES = (INS_ADDR_WIDTH + 7) / 8;
   localparam int HDR_CNT_W = (CNT_BYTES > 1) ? $clog2(CNT_BYTES) : 1;

   loader_state_e             state, next_state;
   logic [8*CNT_BYTES-1:0]    hdr_q;
   logic [HDR_CNT_W-1:0]      hdr_cnt;
   logic [INS_ADDR_WIDTH-1:0] word_idx;
   logic [INS_ADDR_WIDTH-1:0] last_idx;
   logic [INS_ADDR_WIDTH-1:0] addra_q;
   logic [INS_WIDTH-1:0]      dina_q;
   logic [INS_WIDTH-1:0]      asm_word;
   logic                      word_full;
   logic                      accept;
   logic                      start_ok;
   logic                      last_word;

   assign last_idx  = hdr_q[INS_ADDR_WIDTH-1:0];
   assign accept    = bus.s_valid && bus.s_ready;
   assign start_ok  = start && ((state == IDLE) || (state == DONE));
   assign last_word = (word_idx == last_idx);

   // Handshake and status outputs are pure decodes of the state register.
   assign bus.s_ready   = (state == HDR) || (state == DATA) || (state == CHK);
   assign bus.ins_wea   = (state == WRITE);
   assign bus.ins_addra = addra_q;
   assign bus.ins_dina  = dina_q;
   assign busy          = (state == HDR) || (state == DATA) ||
                          (state == WRITE) || (state == CHK);
   assign done          = (state == DONE);

   ins_word_assembler #(
      .INS_WIDTH (INS_WIDTH)
   ) u_asm (
      .clk       (clk),
      .rst       (rst),
      .clear     (start_ok),
      .byte_en   (accept && (state == DATA)),
      .byte_in   (bus.s_data),
      .word      (asm_word),
      .word_full (word_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE, DONE: if (start) next_state = HDR;
         HDR:        if (accept && (hdr_cnt == HDR_CNT_W'(CNT_BYTES - 1))) next_state = DATA;
         DATA:       if (word_full) next_state = WRITE;
`ifdef INS_LOADER_CHECKSUM_EN
         WRITE:      next_state = last_word ? CHK : DATA;
         CHK:        if (accept) next_state = DONE;
`else
         WRITE:      next_state = last_word ? DONE : DATA;
`endif
         default:    next_state = IDLE;
      endcase
   end

   // Header, word index and the held BRAM port-A address/data. The address and
   // data are captured as the last byte arrives, so they are valid throughout
   // WRITE and keep their values afterwards.
   // NOTE: only control/datapath registers are reset; the BRAM is never cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdr_q    <= '0;
         hdr_cnt  <= '0;
         word_idx <= '0;
         addra_q  <= '0;
         dina_q   <= '0;
      end else begin
         if (start_ok) begin
            hdr_q    <= '0;
            hdr_cnt  <= '0;
            word_idx <= '0;
         end
         if ((state == HDR) && accept) begin
            hdr_q[8*hdr_cnt +: 8] <= bus.s_data;
            hdr_cnt               <= hdr_cnt + 1'b1;
         end
         if (word_full) begin
            addra_q <= word_idx;
            dina_q  <= asm_word;
         end
         // last_idx bounds word_idx, so the increment never wraps.
         if ((state == WRITE) && !last_word) begin
            word_idx <= word_idx + 1'b1;
         end
      end
   end

`ifdef INS_LOADER_CHECKSUM_EN
   logic [7:0] xor_accum;
   logic       err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xor_accum <= '0;
         err_q     <= 1'b0;
      end else begin
         if (start_ok) begin
            xor_accum <= '0;
            err_q     <= 1'b0;
         end
         if (accept && ((state == HDR) || (state == DATA))) begin
            xor_accum <= xor_accum ^ bus.s_data;
         end
         if (accept && (state == CHK)) begin
            err_q <= (xor_accum != bus.s_data);
         end
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule : ins_mem_loader

// File: tb/tb_ins_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_ins_mem_loader
// Directed bench for ins_mem_loader: reset, full-rate and stalled loads, the
// full 256-word program, ignored start/extra bytes, reset mid-load and, in
// INS_LOADER_CHECKSUM_EN builds, good and bad checksums.
// -----------------------------------------------------------------------------
module tb_ins_mem_loader;
   import simd_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy, done, err;

   ins_mem_loader_if bus ();

   ins_mem_loader dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  stream [$];
   logic [7:0]  wr_addr [$];
   logic [63:0] wr_data [$];
   int          ready_in_write = 0;

   // Write monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.ins_wea) begin
         wr_addr.push_back(bus.ins_addra);
         wr_data.push_back(bus.ins_dina);
         if (bus.s_ready) ready_in_write++;
      end
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offers one byte after 'gap' idle cycles and returns just after the
   // rising edge on which it was transferred.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         bus.s_valid = 1'b0;
      end
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      n = 0;
      while (!bus.s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("s_ready_wait", {63'd0, bus.s_ready}, 64'd1);
      @(posedge clk);
      #1 bus.s_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("done_wait", {63'd0, done}, 64'd1);
   endtask

   // Full load of the current stream with the given header.
   task automatic do_load(input logic [7:0] hdr, input int max_gap);
      logic [7:0] x;
      x = hdr;
      pulse_start();
      send_byte(hdr, 0);
      foreach (stream[i]) begin
         send_byte(stream[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
         x ^= stream[i];
      end
`ifdef INS_LOADER_CHECKSUM_EN
      send_byte(x, 0);
`endif
      wait_done();
   endtask

   function automatic logic [63:0] exp_word(input int j);
      logic [63:0] w = '0;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = stream[8*j + k];
      return w;
   endfunction

   task automatic verify_writes(input string tag, input int n_words);
      int bad = 0;
      check({tag, "_count"}, wr_addr.size(), n_words);
      for (int j = 0; j < wr_addr.size() && j < n_words; j++) begin
         if (wr_addr[j] !== 8'(j) || wr_data[j] !== exp_word(j)) bad++;
      end
      check({tag, "_words"}, bad, 0);
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_wea",     bus.ins_wea, 0);
      check("rst_addra",   bus.ins_addra, 0);
      check("rst_dina",    bus.ins_dina, 0);
      check("rst_busy",    busy, 0);
      check("rst_done",    done, 0);
      check("rst_err",     err, 0);
      rst = 1'b0;

      // Single word at full rate, cycle-exact.
      pulse_start();
      check("hdr_busy",    busy, 1);
      check("hdr_s_ready", bus.s_ready, 1);
      send_byte(8'h00, 0);
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
      @(negedge clk);
      check("w1_wea",     bus.ins_wea, 1);
      check("w1_addra",   bus.ins_addra, 0);
      check("w1_dina",    bus.ins_dina, 64'h0807060504030201);
      check("w1_s_ready", bus.s_ready, 0);
`ifdef INS_LOADER_CHECKSUM_EN
      @(negedge clk);
      check("w1_chk_ready", bus.s_ready, 1);
      send_byte(8'h08, 0);
      @(negedge clk);
`else
      @(negedge clk);
`endif
      check("w1_done",   done, 1);
      check("w1_busy",   busy, 0);
      check("w1_wea_lo", bus.ins_wea, 0);
      check("w1_err",    err, 0);
      check("w1_dina_hold", bus.ins_dina, 64'h0807060504030201);

`ifdef INS_LOADER_CHECKSUM_EN
      // Bad checksum: err latched, done still asserted; next start clears err.
      pulse_start();
      send_byte(8'h00, 0);
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
      send_byte(8'h09, 0);
      wait_done();
      check("bad_chk_err",  err, 1);
      check("bad_chk_done", done, 1);
      pulse_start();
      check("restart_err",  err, 0);
      check("restart_done", done, 0);
      // Complete this load with a correct checksum.
      send_byte(8'h00, 0);
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
      send_byte(8'h08, 0);
      wait_done();
      check("good_chk_err", err, 0);
`endif

      // Four words with random stalls.
      stream.delete();
      for (int i = 0; i < 32; i++) stream.push_back(8'(8'h10 + i));
      wr_addr.delete(); wr_data.delete();
      ready_in_write = 0;
      do_load(8'h03, 3);
      verify_writes("gap4", 4);
      check("gap4_last_addr", wr_addr[wr_addr.size()-1], 8'h03);
      check("gap4_word3", wr_data[3], 64'h2F2E2D2C2B2A2928);
      check("ready_in_write", ready_in_write, 0);
      check("gap4_busy", busy, 0);

      // Full 256-word program, no wrap.
      stream.delete();
      for (int i = 0; i < 2048; i++) stream.push_back(8'((i * 7 + 3) & 8'hFF));
      wr_addr.delete(); wr_data.delete();
      do_load(8'hFF, 0);
      verify_writes("full", 256);
      check("full_last_addr", wr_addr[wr_addr.size()-1], 8'hFF);
      check("full_addra_hold", bus.ins_addra, 8'hFF);

      // start during DATA is ignored; extra bytes in DONE are refused.
      stream.delete();
      for (int i = 0; i < 16; i++) stream.push_back(8'(8'hC0 + i));
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      send_byte(8'h01, 0);
      for (int i = 0; i < 3; i++) send_byte(stream[i], 0);
      pulse_start();
      check("ign_start_busy",  busy, 1);
      check("ign_start_ready", bus.s_ready, 1);
      for (int i = 3; i < 16; i++) send_byte(stream[i], 1);
`ifdef INS_LOADER_CHECKSUM_EN
      begin
         logic [7:0] x = 8'h01;
         foreach (stream[i]) x ^= stream[i];
         send_byte(x, 0);
      end
`endif
      wait_done();
      verify_writes("ign", 2);
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("done_s_ready", bus.s_ready, 0);
      end
      bus.s_valid = 1'b0;
      check("done_no_write", wr_addr.size(), 2);
      check("done_sticky", done, 1);

      // Reset in the middle of word 2, then reload from address 0.
      stream.delete();
      for (int i = 0; i < 24; i++) stream.push_back(8'(8'h30 + i));
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      send_byte(8'h02, 0);
      for (int i = 0; i < 19; i++) send_byte(stream[i], 0);
      rst = 1'b1;
      #1;
      check("mid_rst_busy",  busy, 0);
      check("mid_rst_ready", bus.s_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_wea",   bus.ins_wea, 0);
      check("mid_rst_addra", bus.ins_addra, 0);
      check("mid_rst_dina",  bus.ins_dina, 0);
      check("mid_rst_done",  done, 0);
      check("mid_rst_err",   err, 0);
      check("mid_rst_writes", wr_addr.size(), 2);
      stream.delete();
      for (int i = 0; i < 8; i++) stream.push_back(8'(8'hA1 + i));
      wr_addr.delete(); wr_data.delete();
      do_load(8'h00, 0);
      verify_writes("reload", 1);
      check("reload_word", wr_data[0], 64'hA8A7A6A5A4A3A2A1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_ins_mem_loader
